ascii_to_scan: RTL and testbench

//  Keystroke synthesiser: turns one Hack key code (ASCII plus nand2tetris specials 128-152) into the
//  PS/2 set-2 make/break byte sequence a keyboard would send. Output is a byte stream with a

---
 rtl/ascii_to_scan.sv | 214 +++++++++++++++++++++
 tb/tb_ascii_to_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ascii_to_scan.sv
// ascii_to_scan: keystroke synthesiser. Turns one Hack key code (ASCII plus
// the nand2tetris specials 128-152) into the PS/2 set-2 make/break byte
// sequence a real keyboard would send, presented as scan_code/scan_ready.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   key_code   Hack key code to type
//   key_valid  key_code valid; accepted when key_valid && key_ready
//   key_ready  high when idle and able to accept a key
//   scan_code  current set-2 byte, stable from scan_ready rise until next byte
//   scan_ready high STROBE_CYCLES per byte, then low GAP_CYCLES
//   done       one-cycle pulse after the last gap of a sequence
//   unmapped   one-cycle pulse when an accepted key has no mapping
module ascii_to_scan #(
    parameter int STROBE_CYCLES = 4,
    parameter int GAP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       done,
    output logic       unmapped
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] HIGH   = 2'd2;
    localparam logic [1:0] LOW    = 2'd3;

    localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    logic [1:0]    state;
    logic [7:0]    key_q;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    len;
    logic [7:0]    seq_q [6];

    // Lookup result for the latched key
    logic [7:0] base_c;
    logic [7:0] make_c;
    logic       shift_c;
    logic       ext_c;
    logic       valid_c;
    logic [7:0] seq_c [6];
    logic [2:0] len_c;

    assign key_ready = (state == IDLE);

    // Shifted symbols and upper case are reduced to the unshifted main-block
    // key first; a single table then gives the make code.
    always_comb begin
        base_c  = key_q;
        shift_c = 1'b0;
        ext_c   = 1'b0;
        make_c  = 8'h00;
        valid_c = 1'b1;
        case (key_q)
            8'h21: begin base_c = "1";   shift_c = 1'b1; end  // !
            8'h22: begin base_c = 8'h27; shift_c = 1'b1; end  // "
            8'h23: begin base_c = "3";   shift_c = 1'b1; end  // #
            8'h24: begin base_c = "4";   shift_c = 1'b1; end  // $
            8'h25: begin base_c = "5";   shift_c = 1'b1; end  // %
            8'h26: begin base_c = "7";   shift_c = 1'b1; end  // &
            8'h28: begin base_c = "9";   shift_c = 1'b1; end  // (
            8'h29: begin base_c = "0";   shift_c = 1'b1; end  // )
            8'h2A: begin base_c = "8";   shift_c = 1'b1; end  // *
            8'h2B: begin base_c = 8'h3D; shift_c = 1'b1; end  // +
            8'h3A: begin base_c = 8'h3B; shift_c = 1'b1; end  // :
            8'h3C: begin base_c = 8'h2C; shift_c = 1'b1; end  // <
            8'h3E: begin base_c = 8'h2E; shift_c = 1'b1; end  // >
            8'h3F: begin base_c = 8'h2F; shift_c = 1'b1; end  // ?
            8'h40: begin base_c = "2";   shift_c = 1'b1; end  // @
            8'h5E: begin base_c = "6";   shift_c = 1'b1; end  // ^
            8'h5F: begin base_c = 8'h2D; shift_c = 1'b1; end  // _
            8'h7B: begin base_c = 8'h5B; shift_c = 1'b1; end  // {
            8'h7C: begin base_c = 8'h5C; shift_c = 1'b1; end  // |
            8'h7D: begin base_c = 8'h5D; shift_c = 1'b1; end  // }
            8'h7E: begin base_c = 8'h60; shift_c = 1'b1; end  // ~
            default: ;
        endcase
        if (key_q >= 8'h41 && key_q <= 8'h5A) begin
            base_c  = key_q | 8'h20;
            shift_c = 1'b1;
        end
        case (base_c)
            "a": make_c = 8'h1C;  "b": make_c = 8'h32;  "c": make_c = 8'h21;
            "d": make_c = 8'h23;  "e": make_c = 8'h24;  "f": make_c = 8'h2B;
            "g": make_c = 8'h34;  "h": make_c = 8'h33;  "i": make_c = 8'h43;
            "j": make_c = 8'h3B;  "k": make_c = 8'h42;  "l": make_c = 8'h4B;
            "m": make_c = 8'h3A;  "n": make_c = 8'h31;  "o": make_c = 8'h44;
            "p": make_c = 8'h4D;  "q": make_c = 8'h15;  "r": make_c = 8'h2D;
            "s": make_c = 8'h1B;  "t": make_c = 8'h2C;  "u": make_c = 8'h3C;
            "v": make_c = 8'h2A;  "w": make_c = 8'h1D;  "x": make_c = 8'h22;
            "y": make_c = 8'h35;  "z": make_c = 8'h1A;
            "0": make_c = 8'h45;  "1": make_c = 8'h16;  "2": make_c = 8'h1E;
            "3": make_c = 8'h26;  "4": make_c = 8'h25;  "5": make_c = 8'h2E;
            "6": make_c = 8'h36;  "7": make_c = 8'h3D;  "8": make_c = 8'h3E;
            "9": make_c = 8'h46;
            8'h20: make_c = 8'h29;  8'h09: make_c = 8'h0D;  8'h27: make_c = 8'h52;
            8'h60: make_c = 8'h0E;  8'h2C: make_c = 8'h41;  8'h2D: make_c = 8'h4E;
            8'h2E: make_c = 8'h49;  8'h2F: make_c = 8'h4A;  8'h3B: make_c = 8'h4C;
            8'h3D: make_c = 8'h55;  8'h5B: make_c = 8'h54;  8'h5C: make_c = 8'h5D;
            8'h5D: make_c = 8'h5B;
            8'd128: make_c = 8'h5A;  8'd129: make_c = 8'h66;  8'd140: make_c = 8'h76;
            8'd141: make_c = 8'h05;  8'd142: make_c = 8'h06;  8'd143: make_c = 8'h04;
            8'd144: make_c = 8'h0C;  8'd145: make_c = 8'h03;  8'd146: make_c = 8'h0B;
            8'd147: make_c = 8'h83;  8'd148: make_c = 8'h0A;  8'd149: make_c = 8'h01;
            8'd150: make_c = 8'h09;  8'd151: make_c = 8'h78;  8'd152: make_c = 8'h07;
            8'd130: begin make_c = 8'h6B; ext_c = 1'b1; end
            8'd131: begin make_c = 8'h75; ext_c = 1'b1; end
            8'd132: begin make_c = 8'h74; ext_c = 1'b1; end
            8'd133: begin make_c = 8'h72; ext_c = 1'b1; end
            8'd134: begin make_c = 8'h6C; ext_c = 1'b1; end
            8'd135: begin make_c = 8'h69; ext_c = 1'b1; end
            8'd136: begin make_c = 8'h7D; ext_c = 1'b1; end
            8'd137: begin make_c = 8'h7A; ext_c = 1'b1; end
            8'd138: begin make_c = 8'h70; ext_c = 1'b1; end
            8'd139: begin make_c = 8'h71; ext_c = 1'b1; end
            default: valid_c = 1'b0;
        endcase
    end

    // Make/break byte list for the looked-up key
    always_comb begin
        for (int i = 0; i < 6; i++) seq_c[i] = 8'h00;
        if (shift_c) begin
            seq_c[0] = 8'h12; seq_c[1] = make_c; seq_c[2] = 8'hF0;
            seq_c[3] = make_c; seq_c[4] = 8'hF0; seq_c[5] = 8'h12;
            len_c = 3'd6;
        end else if (ext_c) begin
            seq_c[0] = 8'hE0; seq_c[1] = make_c; seq_c[2] = 8'hE0;
            seq_c[3] = 8'hF0; seq_c[4] = make_c;
            len_c = 3'd5;
        end else begin
            seq_c[0] = make_c; seq_c[1] = 8'hF0; seq_c[2] = make_c;
            len_c = 3'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            key_q      <= 8'h00;
            scan_code  <= 8'h00;
            scan_ready <= 1'b0;
            done       <= 1'b0;
            unmapped   <= 1'b0;
            cnt        <= '0;
            idx        <= 3'd0;
            len        <= 3'd0;
            for (int i = 0; i < 6; i++) seq_q[i] <= 8'h00;
        end else begin
            done     <= 1'b0;
            unmapped <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_q <= key_code;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!valid_c) begin
                        unmapped <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        for (int i = 0; i < 6; i++) seq_q[i] <= seq_c[i];
                        len        <= len_c;
                        scan_code  <= seq_c[0];
                        scan_ready <= 1'b1;
                        idx        <= 3'd1;
                        cnt        <= '0;
                        state      <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == S_LAST) begin
                        cnt        <= '0;
                        scan_ready <= 1'b0;
                        state      <= LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin  // LOW
                    if (cnt == G_LAST) begin
                        cnt <= '0;
                        if (idx == len) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            scan_code  <= seq_q[idx];
                            scan_ready <= 1'b1;
                            idx        <= idx + 3'd1;
                            state      <= HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_to_scan.sv
module tb_ascii_to_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       done;
    logic       unmapped;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ascii_to_scan #(.STROBE_CYCLES(4), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .scan_code(scan_code), .scan_ready(scan_ready),
        .done(done), .unmapped(unmapped)
    );

    logic [7:0] plain_k [49] = '{
        8'd97, 8'd98, 8'd99, 8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106,
        8'd107, 8'd108, 8'd109, 8'd110, 8'd111, 8'd112, 8'd113, 8'd114, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd119, 8'd120, 8'd121, 8'd122,
        8'd48, 8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57,
        8'd32, 8'd9, 8'd39, 8'd96, 8'd44, 8'd45, 8'd46, 8'd47, 8'd59, 8'd61,
        8'd91, 8'd92, 8'd93};
    logic [7:0] plain_c [49] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h29, 8'h0D, 8'h52, 8'h0E, 8'h41, 8'h4E, 8'h49, 8'h4A, 8'h4C, 8'h55,
        8'h54, 8'h5D, 8'h5B};
    logic [7:0] shift_k [21] = '{
        8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd40, 8'd41, 8'd42, 8'd43,
        8'd58, 8'd60, 8'd62, 8'd63, 8'd64, 8'd94, 8'd95, 8'd123, 8'd124, 8'd125,
        8'd126};
    logic [7:0] sbase_k [21] = '{
        8'd49, 8'd39, 8'd51, 8'd52, 8'd53, 8'd55, 8'd57, 8'd48, 8'd56, 8'd61,
        8'd59, 8'd44, 8'd46, 8'd47, 8'd50, 8'd54, 8'd45, 8'd91, 8'd92, 8'd93,
        8'd96};
    logic [7:0] fkey_c [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
                                8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    logic [7:0] ext_c  [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69,
                                8'h7D, 8'h7A, 8'h70, 8'h71};

    logic [7:0] exp_q [$];

    function automatic int find_plain(input logic [7:0] c);
        for (int i = 0; i < 49; i++)
            if (plain_k[i] == c) return i;
        return -1;
    endfunction

    function automatic int find_shift(input logic [7:0] c);
        for (int i = 0; i < 21; i++)
            if (shift_k[i] == c) return i;
        return -1;
    endfunction

    function automatic bit model(input logic [7:0] k);
        int         i;
        int         kind;
        logic [7:0] mk;
        exp_q.delete();
        kind = 0;
        mk   = 8'h00;
        if (k >= 8'd65 && k <= 8'd90) begin
            mk = plain_c[find_plain(k + 8'd32)]; kind = 1;
        end else if (find_shift(k) >= 0) begin
            mk = plain_c[find_plain(sbase_k[find_shift(k)])]; kind = 1;
        end else if ((i = find_plain(k)) >= 0) begin
            mk = plain_c[i];
        end else if (k == 8'd128) mk = 8'h5A;
        else if (k == 8'd129) mk = 8'h66;
        else if (k == 8'd140) mk = 8'h76;
        else if (k >= 8'd141 && k <= 8'd152) mk = fkey_c[k - 8'd141];
        else if (k >= 8'd130 && k <= 8'd139) begin
            mk = ext_c[k - 8'd130]; kind = 2;
        end else return 1'b0;
        case (kind)
            0: exp_q = '{mk, 8'hF0, mk};
            1: exp_q = '{8'h12, mk, 8'hF0, mk, 8'hF0, 8'h12};
            default: exp_q = '{8'hE0, mk, 8'hE0, 8'hF0, mk};
        endcase
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_scan_code"}, scan_code, 8'h00);
        check({tag, "_scan_ready"}, 8'(scan_ready), 8'h0);
        check({tag, "_done"}, 8'(done), 8'h0);
        check({tag, "_unmapped"}, 8'(unmapped), 8'h0);
        check({tag, "_key_ready"}, 8'(key_ready), 8'h1);
    endtask

    task automatic run_key(input logic [7:0] k, input bit hold, input int abort_t);
        bit mapped;
        int end_t;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!key_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) check("ready_timeout", 8'(key_ready), 8'h1);
        key_code  = k;
        key_valid = 1'b1;
        mapped = model(k);
        end_t  = mapped ? 2 + 8 * exp_q.size() : 2;
        @(posedge clk);
        for (int t = 1; t <= end_t + 1; t++) begin
            @(negedge clk);
            check($sformatf("k%0d_t%0d_key_ready", k, t), 8'(key_ready), 8'(t >= end_t));
            check($sformatf("k%0d_t%0d_done", k, t), 8'(done), 8'(mapped && t == end_t));
            check($sformatf("k%0d_t%0d_unmapped", k, t), 8'(unmapped), 8'(!mapped && t == end_t));
            check($sformatf("k%0d_t%0d_scan_ready", k, t), 8'(scan_ready),
                  8'(mapped && t >= 2 && t < end_t && ((t - 2) % 8) < 4));
            if (mapped && t >= 2 && t <= end_t)
                check($sformatf("k%0d_t%0d_scan_code", k, t), scan_code,
                      exp_q[(t >= end_t) ? exp_q.size() - 1 : (t - 2) / 8]);
            if (t == abort_t) begin
                reset     = 1'b1;
                key_valid = 1'b0;
                @(negedge clk);
                check_reset_vals($sformatf("k%0d_abort", k));
                reset = 1'b0;
                return;
            end
            key_valid = hold && (t < end_t);
            key_code  = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        run_key(8'd97, 1'b0, 0);
        run_key(8'd65, 1'b0, 0);
        run_key(8'd131, 1'b0, 0);
        run_key(8'd128, 1'b0, 0);
        run_key(8'd152, 1'b0, 0);
        run_key(8'd0, 1'b0, 0);
        run_key(8'd200, 1'b0, 0);
        run_key(8'd90, 1'b1, 0);
        run_key(8'd42, 1'b0, 0);
        run_key(8'd9, 1'b0, 0);
        run_key(8'd127, 1'b0, 0);
        run_key(8'd65, 1'b0, 19);
        for (int n = 0; n < 15; n++) run_key(8'($urandom_range(32, 126)), 1'b0, 0);
        for (int n = 0; n < 10; n++) run_key(8'($urandom_range(0, 255)), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
